// File: rtl/data_memory_responder.sv
// Data-side memory responder: little-endian byte RAM, a 16-byte MMIO window
// (cycle counter, TOHOST halt port, STATUS) and sticky access-error capture.
package data_memory_responder_pkg;
   typedef enum logic [3:0] {
      MEM_NONE, MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW
   } mem_op_t;
endpackage

module data_memory_responder
   import data_memory_responder_pkg::*;
#(
   parameter int unsigned MEM_SIZE_BYTES = 1024,
   parameter logic [31:0] MMIO_BASE      = 32'h1000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_wr_en,
   input  mem_op_t     mem_op,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_data_in,
   output logic [31:0] mem_data_out,
   output logic        halt,
   output logic [31:0] halt_code,
   output logic        err,
   output logic [31:0] err_addr
);
   localparam int unsigned WORDS = MEM_SIZE_BYTES / 4;
   localparam int unsigned IDX_W = $clog2(WORDS);

   logic [31:0] ram [WORDS];
   logic [63:0] cycle_cnt;
   logic [31:0] shadow;

   logic             is_load, is_store, is_access;
   logic             in_ram, in_mmio, misaligned, fault;
   logic             ram_we, mmio_rd, mmio_wr;
   logic [31:0]      mmio_off;
   logic [1:0]       mmio_reg;
   logic [IDX_W-1:0] word_idx;
   logic [31:0]      ram_word, mmio_word, wdata;
   logic [3:0]       be;
   logic [7:0]       sel_byte;
   logic [15:0]      sel_half;

   assign word_idx = mem_addr[IDX_W+1:2];
   assign ram_word = ram[word_idx];
   assign mmio_off = mem_addr - MMIO_BASE;
   assign mmio_reg = mmio_off[3:2];

   // NOTE: combinational decode uses blocking assignments with a default for
   // every output first, so no path leaves a signal unassigned (no latch).
   always_comb begin
      is_load    = mem_op inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
      is_store   = mem_wr_en && (mem_op inside {MEM_SB, MEM_SH, MEM_SW});
      is_access  = is_load || is_store;
      in_ram     = mem_addr < 32'(MEM_SIZE_BYTES);
      in_mmio    = (mem_addr >= MMIO_BASE) && (mmio_off < 32'd16);
      misaligned = 1'b0;
      case (mem_op)
         MEM_LH, MEM_LHU, MEM_SH: misaligned = mem_addr[0];
         MEM_LW, MEM_SW:          misaligned = mem_addr[1:0] != 2'b00;
         default:                 misaligned = 1'b0;
      endcase
      // MMIO registers only accept full-word accesses.
      fault   = is_access && (misaligned || !(in_ram || in_mmio) ||
                              (in_mmio && !(mem_op inside {MEM_LW, MEM_SW})));
      ram_we  = is_store && !fault && in_ram;
      mmio_rd = is_load  && !fault && in_mmio;
      mmio_wr = is_store && !fault && in_mmio;

      be    = 4'b0000;
      wdata = mem_data_in;
      case (mem_op)
         MEM_SB: begin be = 4'b0001 << mem_addr[1:0]; wdata = {4{mem_data_in[7:0]}};  end
         MEM_SH: begin be = mem_addr[1] ? 4'b1100 : 4'b0011; wdata = {2{mem_data_in[15:0]}}; end
         MEM_SW: be = 4'b1111;
         default: be = 4'b0000;
      endcase

      case (mem_addr[1:0])
         2'd0:    sel_byte = ram_word[7:0];
         2'd1:    sel_byte = ram_word[15:8];
         2'd2:    sel_byte = ram_word[23:16];
         default: sel_byte = ram_word[31:24];
      endcase
      sel_half = mem_addr[1] ? ram_word[31:16] : ram_word[15:0];

      case (mmio_reg)
         2'd0:    mmio_word = cycle_cnt[31:0];
         2'd1:    mmio_word = shadow;
         2'd2:    mmio_word = halt_code;
         default: mmio_word = {31'b0, err};
      endcase

      mem_data_out = 32'b0;
      if (is_load && !fault) begin
         if (in_mmio) begin
            mem_data_out = mmio_word;
         end else begin
            case (mem_op)
               MEM_LB:  mem_data_out = {{24{sel_byte[7]}}, sel_byte};
               MEM_LBU: mem_data_out = {24'b0, sel_byte};
               MEM_LH:  mem_data_out = {{16{sel_half[15]}}, sel_half};
               MEM_LHU: mem_data_out = {16'b0, sel_half};
               MEM_LW:  mem_data_out = ram_word;
               default: mem_data_out = 32'b0;
            endcase
         end
      end
   end

   // NOTE: the RAM array has no reset branch; contents survive reset and the
   // array can map onto block RAM. Reset only gates the write enable.
   always_ff @(posedge clk) begin
      if (!reset && ram_we) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) ram[word_idx][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cycle_cnt <= 64'b0;
         shadow    <= 32'b0;
         halt      <= 1'b0;
         halt_code <= 32'b0;
         err       <= 1'b0;
         err_addr  <= 32'b0;
      end else begin
         cycle_cnt <= cycle_cnt + 64'd1;
         // Snapshot the high half on every CNT_LO read so LO-then-HI is coherent.
         if (mmio_rd && mmio_reg == 2'd0) shadow <= cycle_cnt[63:32];
         if (mmio_wr && mmio_reg == 2'd2 && !halt) begin
            halt      <= 1'b1;
            halt_code <= mem_data_in;
         end
         if (fault) begin
            err <= 1'b1;
            if (!err) err_addr <= mem_addr;
         end else if (mmio_wr && mmio_reg == 2'd3) begin
            err      <= 1'b0;
            err_addr <= 32'b0;
         end
      end
   end
endmodule

// File: tb/tb_data_memory_responder.sv
// Directed and randomized bench for data_memory_responder, checked against a
// byte-level reference model of the memory map.
module tb_data_memory_responder;
   import data_memory_responder_pkg::*;

   localparam int unsigned MEM  = 1024;
   localparam logic [31:0] BASE = 32'h1000_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        mem_wr_en = 1'b0;
   mem_op_t     mem_op = MEM_NONE;
   logic [31:0] mem_addr = 32'b0;
   logic [31:0] mem_data_in = 32'b0;
   logic [31:0] mem_data_out;
   logic        halt;
   logic [31:0] halt_code;
   logic        err;
   logic [31:0] err_addr;

   int checks = 0;
   int failures = 0;

   // reference model state
   logic [7:0]  m_ram [MEM];
   logic [63:0] m_cnt;
   logic [31:0] m_shadow, m_halt_code, m_err_addr;
   logic        m_halt, m_err;

   data_memory_responder #(.MEM_SIZE_BYTES(MEM), .MMIO_BASE(BASE)) dut (
      .clk(clk), .reset(reset), .mem_wr_en(mem_wr_en), .mem_op(mem_op),
      .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
      .halt(halt), .halt_code(halt_code), .err(err), .err_addr(err_addr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Expected load value from the current model state, then advance the model one edge.
   task automatic model_step(input logic rst, input logic wr, input mem_op_t op,
                             input logic [31:0] addr, input logic [31:0] data,
                             output logic [31:0] exp);
      int w;
      bit ld, st, sgn, ram_hit, io_hit, bad;
      logic [31:0] v, off;
      ld = op inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
      st = wr && (op inside {MEM_SB, MEM_SH, MEM_SW});
      case (op)
         MEM_LB, MEM_LBU, MEM_SB: w = 1;
         MEM_LH, MEM_LHU, MEM_SH: w = 2;
         MEM_LW, MEM_SW:          w = 4;
         default:                 w = 0;
      endcase
      sgn     = op inside {MEM_LB, MEM_LH};
      ram_hit = addr < MEM;
      io_hit  = (64'(addr) >= 64'(BASE)) && (64'(addr) <= 64'(BASE) + 64'd15);
      off     = addr - BASE;
      bad     = (ld || st) && ((w > 1 && (addr % w) != 0) || (!ram_hit && !io_hit) ||
                               (io_hit && w != 4));
      exp = 32'b0;
      if (ld && !bad) begin
         if (io_hit) begin
            case (off)
               32'd0:   exp = m_cnt[31:0];
               32'd4:   exp = m_shadow;
               32'd8:   exp = m_halt_code;
               default: exp = {31'b0, m_err};
            endcase
         end else begin
            v = 32'b0;
            for (int k = 0; k < w; k++) v = v | (32'(m_ram[addr + k]) << (8 * k));
            if (sgn && v[8*w-1]) v = v | (32'hFFFF_FFFF << (8 * w));
            exp = v;
         end
      end
      if (rst) begin
         m_cnt = 64'b0; m_shadow = 32'b0; m_halt = 1'b0; m_halt_code = 32'b0;
         m_err = 1'b0;  m_err_addr = 32'b0;
      end else begin
         if (st && !bad && ram_hit)
            for (int k = 0; k < w; k++) m_ram[addr + k] = 8'(data >> (8 * k));
         if (ld && !bad && io_hit && off == 32'd0) m_shadow = m_cnt[63:32];
         if (st && !bad && io_hit && off == 32'd8 && !m_halt) begin
            m_halt = 1'b1; m_halt_code = data;
         end
         if (bad) begin
            if (!m_err) m_err_addr = addr;
            m_err = 1'b1;
         end else if (st && io_hit && off == 32'd12) begin
            m_err = 1'b0; m_err_addr = 32'b0;
         end
         m_cnt = m_cnt + 64'd1;
      end
   endtask

   // One bus cycle: drive at negedge, check load data mid-cycle, check state after the edge.
   task automatic step(input logic rst, input logic wr, input mem_op_t op,
                       input logic [31:0] addr, input logic [31:0] data,
                       input string tag, output logic [31:0] obs);
      logic [31:0] exp;
      @(negedge clk);
      reset = rst; mem_wr_en = wr; mem_op = op; mem_addr = addr; mem_data_in = data;
      #1;
      model_step(rst, wr, op, addr, data, exp);
      obs = mem_data_out;
      check({tag, ".data"}, obs, exp);
      @(posedge clk);
      #1;
      check({tag, ".err"},       err,       m_err);
      check({tag, ".err_addr"},  err_addr,  m_err_addr);
      check({tag, ".halt"},      halt,      m_halt);
      check({tag, ".halt_code"}, halt_code, m_halt_code);
   endtask

   initial begin
      logic [31:0] o, a;
      mem_op_t     op;
      logic        wr, rst;
      int          region;

      // reset and counter start
      step(1, 0, MEM_NONE, 0, 0, "rst0", o);
      step(1, 0, MEM_NONE, 0, 0, "rst1", o);
      check("rst.err", err, 0);
      check("rst.halt", halt, 0);
      step(0, 0, MEM_LW, BASE, 0, "cnt0", o);
      check("cnt_first", o, 0);
      step(0, 0, MEM_LW, BASE, 0, "cnt1", o);
      check("cnt_second", o, 1);

      // give every RAM byte a defined value
      for (int i = 0; i < MEM / 4; i++) step(0, 1, MEM_SW, 32'(4 * i), $urandom, "init", o);
      step(0, 1, MEM_SW, 32'h0, 32'hCAFE_F00D, "seed0", o);
      step(0, 1, MEM_SW, 32'h20, 32'h0000_0011, "seed20", o);

      // sub-word store/load
      step(0, 1, MEM_SW, 32'h10, 32'hDEAD_BEEF, "sw10", o);
      step(0, 1, MEM_SB, 32'h11, 32'h0000_007F, "sb11", o);
      step(0, 0, MEM_LW, 32'h10, 0, "lw10", o);   check("lw10_val", o, 32'hDEAD_7FEF);
      step(0, 0, MEM_LB, 32'h11, 0, "lb11", o);   check("lb11_val", o, 32'h0000_007F);
      step(0, 0, MEM_LH, 32'h12, 0, "lh12", o);   check("lh12_val", o, 32'hFFFF_DEAD);
      step(0, 0, MEM_LHU, 32'h12, 0, "lhu12", o); check("lhu12_val", o, 32'h0000_DEAD);

      // misalignment and first-fault capture
      step(0, 0, MEM_LW, 32'h6, 0, "lw6", o);
      check("lw6_val", o, 0);
      check("lw6_err", err, 1);
      check("lw6_err_addr", err_addr, 32'h6);
      step(0, 1, MEM_SH, 32'h3, 32'hFFFF, "sh3", o);
      check("sh3_err_addr", err_addr, 32'h6);
      step(0, 1, MEM_SW, BASE + 32'hC, 32'h5A, "clr", o);
      check("clr_err", err, 0);

      // out of range store, then reset in the middle of a store
      step(0, 1, MEM_SW, 32'(MEM), 32'h1234, "oor", o);
      check("oor_err_addr", err_addr, 32'h400);
      step(1, 1, MEM_SW, 32'h20, 32'hAA, "rst_store", o);
      check("rst_store_err", err, 0);
      step(0, 0, MEM_LW, 32'h20, 0, "lw20", o);  check("lw20_val", o, 32'h11);
      step(0, 1, MEM_LW, 32'h0, 32'h5555, "wr_load", o);
      step(0, 0, MEM_LW, 32'h0, 0, "lw0", o);    check("lw0_val", o, 32'hCAFE_F00D);

      // coherent counter snapshot across the 32-bit wrap
      force dut.cycle_cnt = 64'h0000_0000_FFFF_FFFF;
      #1 release dut.cycle_cnt;
      m_cnt = 64'h0000_0000_FFFF_FFFF;
      step(0, 0, MEM_LW, BASE, 0, "cntlo", o);       check("cntlo_val", o, 32'hFFFF_FFFF);
      step(0, 0, MEM_LW, BASE + 32'h4, 0, "cnthi", o); check("cnthi_val", o, 32'h0);
      step(0, 1, MEM_SW, BASE + 32'h4, 32'h77, "cnthi_wr", o);

      // randomized traffic over all regions
      for (int n = 0; n < 1500; n++) begin
         op = mem_op_t'($urandom_range(0, 8));
         region = $urandom_range(0, 9);
         if (region <= 5)      a = $urandom_range(0, 63);
         else if (region == 6) a = $urandom_range(0, MEM - 1);
         else if (region <= 8) a = BASE + $urandom_range(0, 15);
         else begin
            case ($urandom_range(0, 3))
               0:       a = MEM + $urandom_range(0, 63);
               1:       a = BASE - 4 + $urandom_range(0, 3);
               2:       a = BASE + 16 + $urandom_range(0, 15);
               default: a = $urandom | 32'h8000_0000;
            endcase
         end
         wr = (op inside {MEM_SB, MEM_SH, MEM_SW}) ? 1'b1 : ($urandom_range(0, 3) == 0);
         if (wr && !(op inside {MEM_SB, MEM_SH, MEM_SW})) a = 32'($urandom_range(0, 15)) << 2;
         rst = ($urandom_range(0, 99) == 0);
         step(rst, wr, op, a, $urandom, $sformatf("rnd%0d", n), o);
      end

      // halt sequence
      step(1, 0, MEM_NONE, 0, 0, "rst_h", o);
      step(0, 1, MEM_SW, BASE + 32'h8, 32'h1, "host1", o);
      check("host1_halt", halt, 1);
      check("host1_code", halt_code, 1);
      step(0, 1, MEM_SW, BASE + 32'h8, 32'h2, "host2", o);
      check("host2_code", halt_code, 1);
      step(0, 0, MEM_LW, BASE + 32'h8, 0, "host_rd", o); check("host_rd_val", o, 1);
      step(0, 1, MEM_SW, 32'h30, 32'h0BAD_CAFE, "halted_sw", o);
      step(0, 0, MEM_LW, 32'h30, 0, "halted_lw", o);   check("halted_lw_val", o, 32'h0BAD_CAFE);
      step(1, 0, MEM_NONE, 0, 0, "rst_end", o);
      check("rst_end_halt", halt, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
